// File: rtl/countdown_timer_mmss.sv
// BCD MM:SS countdown timer with expiry pulse and timed alarm window.
// Optional COUNTDOWN_AUTO_RELOAD_EN: on expiry reload the last preset and keep running.
module countdown_timer_mmss #(
    parameter int MAX_MIN    = 59,
    parameter int ALARM_SECS = 10
) (
    input  logic       TICK,
    input  logic       RESET_N,
    input  logic       SEC_PULSE,
    input  logic       LOAD,
    input  logic       START,
    input  logic       STOP,
    input  logic [3:0] PRE_M_T,
    input  logic [3:0] PRE_M_O,
    input  logic [3:0] PRE_S_T,
    input  logic [3:0] PRE_S_O,
    output logic [3:0] Q_M_T,
    output logic [3:0] Q_M_O,
    output logic [3:0] Q_S_T,
    output logic [3:0] Q_S_O,
    output logic       Q_DONE,
    output logic       ALARM,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_EXP   = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_t;

    localparam int          CW     = $clog2(ALARM_SECS + 2);
    localparam logic [CW-1:0] CNT_LD = CW'(ALARM_SECS);
    localparam logic [6:0]  MAX7   = 7'(MAX_MIN);
    localparam logic [3:0]  MAX_T  = 4'(MAX_MIN / 10);
    localparam logic [3:0]  MAX_O  = 4'(MAX_MIN % 10);
    localparam bcd_t        ONE    = '{mt: 4'd0, mo: 4'd0, st: 4'd0, so: 4'd1};

    state_t        state_q, state_d;
    bcd_t          cur, nxt, pre_c, dec;
    logic          done_q, done_d;
    logic          alarm_q, alarm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    min_val;
    logic          is_zero, is_one, load_ok;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    bcd_t          shadow_q, shadow_d;
`endif

    // Per-digit clamp first, then cap the combined minute value.
    always_comb begin
        pre_c.mt = (PRE_M_T > 4'd9) ? 4'd9 : PRE_M_T;
        pre_c.mo = (PRE_M_O > 4'd9) ? 4'd9 : PRE_M_O;
        pre_c.st = (PRE_S_T > 4'd5) ? 4'd5 : PRE_S_T;
        pre_c.so = (PRE_S_O > 4'd9) ? 4'd9 : PRE_S_O;
        min_val  = 7'(pre_c.mt) * 7'd10 + 7'(pre_c.mo);
        if (min_val > MAX7) begin
            pre_c.mt = MAX_T;
            pre_c.mo = MAX_O;
        end
    end

    // One-second BCD borrow chain.
    always_comb begin
        dec = cur;
        if (cur.so != 4'd0) begin
            dec.so = cur.so - 4'd1;
        end else begin
            dec.so = 4'd9;
            if (cur.st != 4'd0) begin
                dec.st = cur.st - 4'd1;
            end else begin
                dec.st = 4'd5;
                if (cur.mo != 4'd0) begin
                    dec.mo = cur.mo - 4'd1;
                end else begin
                    dec.mo = 4'd9;
                    dec.mt = cur.mt - 4'd1;
                end
            end
        end
    end

    assign is_zero = (cur == '0);
    assign is_one  = (cur == ONE);
    assign load_ok = LOAD && (state_q != S_RUN);

    always_comb begin
        nxt     = cur;
        state_d = state_q;
        done_d  = 1'b0;
        alarm_d = alarm_q;
        cnt_d   = cnt_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        shadow_d = shadow_q;
`endif
        if (load_ok) begin
            nxt     = pre_c;
            state_d = S_IDLE;
            alarm_d = 1'b0;
            cnt_d   = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_d = pre_c;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!STOP && START && !is_zero) state_d = S_RUN;
                end
                S_RUN: begin
                    if (STOP) begin
                        state_d = S_PAUSE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        alarm_d = 1'b0;
                        cnt_d   = '0;
`endif
                    end else if (!START && SEC_PULSE) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        // Alarm window keeps timing out while the count continues.
                        if (alarm_q) begin
                            if (cnt_q <= CW'(1)) begin
                                alarm_d = 1'b0;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q - CW'(1);
                            end
                        end
`endif
                        if (is_one) begin
                            done_d  = 1'b1;
                            alarm_d = 1'b1;
                            cnt_d   = CNT_LD;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            nxt     = shadow_q;
`else
                            nxt     = '0;
                            state_d = S_EXP;
`endif
                        end else if (!is_zero) begin
                            nxt = dec;
                        end
                    end
                end
                S_PAUSE: begin
                    if (!STOP && START && !is_zero) state_d = S_RUN;
                end
                S_EXP: begin
                    if (STOP) begin
                        alarm_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else if (!START && SEC_PULSE) begin
                        if (cnt_q <= CW'(1)) begin
                            alarm_d = 1'b0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge TICK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cur     <= '0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur     <= nxt;
            done_q  <= done_d;
            alarm_q <= alarm_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge TICK or negedge RESET_N) begin
        if (!RESET_N) shadow_q <= '0;
        else          shadow_q <= shadow_d;
    end
`endif

    assign Q_M_T  = cur.mt;
    assign Q_M_O  = cur.mo;
    assign Q_S_T  = cur.st;
    assign Q_S_O  = cur.so;
    assign Q_DONE = done_q;
    assign ALARM  = alarm_q;
    assign STATE  = state_q;

endmodule
